// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: ID-stage load-use stall and branch/jump flush control; HAZARD_PERF_CNT_EN adds event counters
module hazard_detection_unit #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Rt,
  input  logic [4:0] IF_ID_Rs,
  input  logic [4:0] IF_ID_Rt,
  input  logic       BranchTaken,
  input  logic       Jump,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       ID_EX_Bubble,
  output logic       IF_ID_Flush,
  output logic       Stalling
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] StallEvents,
  output logic [15:0] FlushEvents
`endif
);
  typedef enum logic {RUN, STALL} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic lu_hz, in_stall, hold;
  assign lu_hz = ID_EX_MemRead && (ID_EX_Rt != 5'd0) && (ID_EX_Rt == IF_ID_Rs || ID_EX_Rt == IF_ID_Rt);
  assign in_stall = state_q == STALL;
  // reset low overrides everything so a stall in progress is dropped at once
  assign hold = reset && (in_stall || lu_hz);
  always_comb begin
    PCWrite = !hold;
    IF_ID_Write = !hold;
    ID_EX_Bubble = hold;
    IF_ID_Flush = reset && !hold && (BranchTaken || Jump);
    Stalling = reset && in_stall;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (in_stall) begin
      state_d = cnt_q == '0 ? RUN : STALL;
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
    end else if (lu_hz && LOAD_STALL_CYCLES > 1) begin
      state_d = STALL;
      cnt_d = CNT_W'(LOAD_STALL_CYCLES - 2);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_ev_q, stall_ev_d, flush_ev_q, flush_ev_d;
  always_comb begin
    stall_ev_d = (!in_stall && lu_hz && stall_ev_q != 16'hFFFF) ? stall_ev_q + 16'd1 : stall_ev_q;
    flush_ev_d = (IF_ID_Flush && flush_ev_q != 16'hFFFF) ? flush_ev_q + 16'd1 : flush_ev_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_ev_q <= '0;
      flush_ev_q <= '0;
    end else begin
      stall_ev_q <= stall_ev_d;
      flush_ev_q <= flush_ev_d;
    end
  end
  assign StallEvents = stall_ev_q;
  assign FlushEvents = flush_ev_q;
`endif
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: vector table plus stall/flush/reset sequences for 1- and 3-bubble builds
module tb_hazard_detection_unit;
  logic clk = 0;
  logic reset, mr, br, jmp;
  logic [4:0] ex_rt, rs, rt;
  logic pc1, ifw1, bub1, fl1, st1;
  logic pc3, ifw3, bub3, fl3, st3;
  int errors = 0, checks = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] se1, fe1, se3, fe3;
`endif
  always #5 clk = ~clk;
  hazard_detection_unit dut1 (
    .clk(clk), .reset(reset), .ID_EX_MemRead(mr), .ID_EX_Rt(ex_rt), .IF_ID_Rs(rs), .IF_ID_Rt(rt),
    .BranchTaken(br), .Jump(jmp), .PCWrite(pc1), .IF_ID_Write(ifw1), .ID_EX_Bubble(bub1),
    .IF_ID_Flush(fl1), .Stalling(st1)
`ifdef HAZARD_PERF_CNT_EN
    , .StallEvents(se1), .FlushEvents(fe1)
`endif
  );
  hazard_detection_unit #(.LOAD_STALL_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .ID_EX_MemRead(mr), .ID_EX_Rt(ex_rt), .IF_ID_Rs(rs), .IF_ID_Rt(rt),
    .BranchTaken(br), .Jump(jmp), .PCWrite(pc3), .IF_ID_Write(ifw3), .ID_EX_Bubble(bub3),
    .IF_ID_Flush(fl3), .Stalling(st3)
`ifdef HAZARD_PERF_CNT_EN
    , .StallEvents(se3), .FlushEvents(fe3)
`endif
  );
  typedef struct {
    logic rst, mr; logic [4:0] ex_rt, rs, rt; logic br, j; logic [4:0] exp;
  } vec_t;
  // expected word is {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Stalling}
  localparam logic [4:0] RUNV = 5'b11000, BUB = 5'b00100, FLU = 5'b11010, STL = 5'b00101;
  vec_t tbl [12];
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic drive(input logic r, m, input logic [4:0] e, s, t, input logic b, jj);
    reset = r; mr = m; ex_rt = e; rs = s; rt = t; br = b; jmp = jj;
  endtask
  task automatic cyc;
    @(posedge clk); #1;
  endtask
  function automatic logic [15:0] o1();
    return {11'd0, pc1, ifw1, bub1, fl1, st1};
  endfunction
  function automatic logic [15:0] o3();
    return {11'd0, pc3, ifw3, bub3, fl3, st3};
  endfunction
  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, RUNV};
    tbl[1]  = '{1, 1, 8, 8, 0, 0, 0, BUB};
    tbl[2]  = '{1, 1, 8, 3, 8, 0, 0, BUB};
    tbl[3]  = '{1, 1, 0, 0, 0, 0, 0, RUNV};
    tbl[4]  = '{1, 0, 8, 8, 0, 0, 0, RUNV};
    tbl[5]  = '{1, 1, 8, 9, 10, 0, 0, RUNV};
    tbl[6]  = '{1, 0, 0, 0, 0, 1, 0, FLU};
    tbl[7]  = '{1, 0, 0, 0, 0, 0, 1, FLU};
    tbl[8]  = '{1, 1, 8, 8, 0, 0, 1, BUB};
    tbl[9]  = '{1, 1, 0, 0, 0, 1, 0, FLU};
    tbl[10] = '{0, 1, 8, 8, 0, 1, 0, RUNV};
    tbl[11] = '{1, 1, 31, 31, 2, 0, 0, BUB};
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc; cyc;
    @(negedge clk);
    check("reset_l1", o1(), 16'(RUNV));
    check("reset_l3", o3(), 16'(RUNV));
    cyc;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rst, tbl[i].mr, tbl[i].ex_rt, tbl[i].rs, tbl[i].rt, tbl[i].br, tbl[i].j);
      @(negedge clk);
      check($sformatf("vec%0d", i), o1(), 16'(tbl[i].exp));
      cyc;
    end
    drive(0, 0, 0, 0, 0, 0, 0); cyc;
    drive(1, 0, 0, 0, 0, 0, 0); cyc;
    // three-bubble stall, branch ignored during the STALL cycles
    drive(1, 1, 8, 8, 0, 0, 0);
    @(negedge clk); check("l3_c1", o3(), 16'(BUB)); check("l1_c1", o1(), 16'(BUB));
    cyc; drive(1, 0, 0, 0, 0, 1, 0);
    @(negedge clk); check("l3_c2", o3(), 16'(STL)); check("l1_c2_flush", o1(), 16'(FLU));
    cyc;
    @(negedge clk); check("l3_c3", o3(), 16'(STL));
    cyc; drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); check("l3_c4", o3(), 16'(RUNV));
    cyc;
    // branch colliding with a hazard: stall first, then a single flush
    drive(1, 1, 8, 8, 0, 1, 0);
    @(negedge clk); check("brhz_c1", o1(), 16'(BUB));
    cyc; drive(1, 0, 0, 0, 0, 1, 0);
    @(negedge clk); check("brhz_c2", o1(), 16'(FLU));
    cyc; drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); check("brhz_c3", o1(), 16'(RUNV));
    cyc;
    // reset during the second cycle of a three-cycle stall
    drive(1, 1, 8, 8, 0, 0, 0); cyc;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); check("rst_mid_forced", o3(), 16'(RUNV));
    cyc; drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); check("rst_mid_after", o3(), 16'(RUNV));
    cyc;
    @(negedge clk); check("rst_mid_after2", o3(), 16'(RUNV));
    cyc;
`ifdef HAZARD_PERF_CNT_EN
    drive(0, 0, 0, 0, 0, 0, 0); cyc;
    drive(1, 1, 8, 8, 0, 0, 0); cyc;
    drive(1, 0, 0, 0, 0, 1, 0); cyc;
    drive(1, 1, 5, 0, 5, 0, 0); cyc;
    drive(1, 0, 0, 0, 0, 0, 1); cyc;
    drive(1, 0, 0, 0, 0, 1, 0); cyc;
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("stall_events", se1, 16'd2);
    check("flush_events", fe1, 16'd3);
    drive(1, 1, 8, 8, 0, 0, 0);
    for (int i = 0; i < 65540; i++) cyc;
    @(negedge clk);
    check("stall_events_sat", se1, 16'hFFFF);
    drive(1, 0, 0, 0, 0, 0, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
